mips_cpu_sequencer: RTL
=======================

MIPS_CPU_SEQUENCER -- requirements
Module: mips_cpu_sequencer

Interface
REQ-001 The module SHALL have ports clk (input, 1 bit, clock) and reset (input, 1 bit); reset is asynchronous and active-high.
REQ-002 waitrequest  input  1  memory bus stall; the current bus transfer is not yet accepted.
REQ-003 pc  input  32  current program counter from the datapath.
REQ-004 is_load, is_store  input  1 each  decoded class of the instruction held in the IR.
REQ-005 div_busy  input  1  multi-cycle divider still computing.
REQ-006 active  output  1  CPU running; low once halted.
REQ-007 mem_read, mem_write  output  1 each  bus read and write strobes.
REQ-008 addr_sel  output  1  bus address select: 0 = pc, 1 = ALU result.
REQ-009 ir_write, pc_write, reg_write  output  1 each  datapath register load enables.
REQ-010 state  output  3  current state encoding, for debug.

Function
REQ-011 The block SHALL be a Moore-plus-stall FSM with states HALTED=0, FETCH=1, EXEC=2, MEM=3, WB=4; encodings 5-7 SHALL go to HALTED on the next clock.
REQ-012 Every output except active and state SHALL be 0 unless this section asserts it.
REQ-013 FETCH with pc==32'h0: mem_read=0; next state HALTED; the bus is never accessed.
REQ-014 FETCH with pc!=0: mem_read=1 and addr_sel=0.
REQ-015 FETCH with pc!=0 and waitrequest=1: remain in FETCH.
REQ-016 FETCH with pc!=0 and waitrequest=0: ir_write=1 for exactly that cycle; next state EXEC.
REQ-017 EXEC with div_busy=1: remain in EXEC; no enables asserted.
REQ-018 EXEC with div_busy=0: next state MEM if is_load or is_store is 1, otherwise WB.
REQ-019 MEM: addr_sel=1; mem_read=is_load; mem_write=is_store & ~is_load.
- is_load has priority when both is_load and is_store are 1.
- Hold in MEM while waitrequest=1.
REQ-020 MEM with waitrequest=0: a load goes to WB; a store asserts pc_write=1 for that cycle and goes to FETCH.
REQ-021 WB: reg_write=1 and pc_write=1 for exactly one cycle; next state FETCH.
REQ-022 mem_read and mem_write SHALL never be high in the same cycle.
REQ-023 A bus strobe, once raised, SHALL stay stable until the cycle in which waitrequest=0.
REQ-024 active SHALL be 1 in every state except HALTED.
REQ-025 HALTED SHALL be absorbing; only reset leaves it.
REQ-026 Minimum latency per instruction:
- ALU instruction: 3 cycles (FETCH, EXEC, WB).
- Store: 3 cycles (FETCH, EXEC, MEM).
- Load: 4 cycles (FETCH, EXEC, MEM, WB).
- Each waitrequest or div_busy cycle adds one cycle.

Reset
REQ-027 While reset=1, the outputs SHALL be forced immediately, without waiting for a clock: state=FETCH, active=1, all strobes and enables=0.
REQ-028 Reset asserted mid-transfer (FETCH or MEM with waitrequest=1) SHALL drop mem_read and mem_write in the same cycle.
REQ-029 The first FETCH strobe after reset SHALL occur in the first clk cycle after reset deasserts, subject to REQ-013.

Configuration
REQ-030 Macro MIPS_CPU_SEQ_CYCLE_COUNT_EN defined: extra output cycle_count, 32 bits.
- Reset value 0.
- Increments by one on every clock while active=1.
- Wraps from 32'hFFFFFFFF to 0.
- Holds its value in HALTED.
REQ-031 MIPS_CPU_SEQ_CYCLE_COUNT_EN undefined: the cycle_count port and its counter SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-032 Reset, then pc=32'h0 -> one FETCH cycle with mem_read=0, then HALTED with active=0, held for 100 cycles.
REQ-033 pc=32'hBFC00000, ALU op, waitrequest=0 -> state sequence 1,2,4,1; ir_write in cycle 1; reg_write and pc_write together in cycle 3.
REQ-034 Load with waitrequest=1 for 3 MEM cycles -> mem_read=1 and addr_sel=1 stable for 4 cycles, then WB with reg_write=1.
REQ-035 is_load=1 and is_store=1 together -> mem_write=0 throughout MEM; path via WB as for a load.
REQ-036 div_busy=1 for 5 cycles in EXEC -> state=2 for 6 cycles, no enables; reset asserted mid-FETCH stall -> mem_read=0 immediately, state=1.
REQ-037 With MIPS_CPU_SEQ_CYCLE_COUNT_EN: preload the counter to 32'hFFFFFFFE, run 3 active cycles -> 1; after halt the value stays constant.

Source files
------------

// File: rtl/mips_cpu_sequencer.sv
// mips_cpu_sequencer: multi-cycle MIPS control sequencer (FETCH/EXEC/MEM/WB).
// Outputs are a Moore decode of the state plus the bus/divider stall inputs.
// Optional build macro MIPS_CPU_SEQ_CYCLE_COUNT_EN adds a 32-bit active-cycle counter.
module mips_cpu_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        waitrequest,
  input  logic [31:0] pc,
  input  logic        is_load,
  input  logic        is_store,
  input  logic        div_busy,
  output logic        active,
  output logic        mem_read,
  output logic        mem_write,
  output logic        addr_sel,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic [2:0]  state
`ifdef MIPS_CPU_SEQ_CYCLE_COUNT_EN
  ,
  output logic [31:0] cycle_count
`endif
);

  localparam int unsigned STATE_W = 3;
  localparam int unsigned CNT_W   = 32;

  localparam logic [STATE_W-1:0] ST_HALTED = 3'd0;
  localparam logic [STATE_W-1:0] ST_FETCH  = 3'd1;
  localparam logic [STATE_W-1:0] ST_EXEC   = 3'd2;
  localparam logic [STATE_W-1:0] ST_MEM    = 3'd3;
  localparam logic [STATE_W-1:0] ST_WB     = 3'd4;

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;
  logic               pc_is_zero;

  assign pc_is_zero = (pc == 32'h0);

  // State register; reset lands directly in FETCH so the first fetch follows release
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; undefined encodings fall into HALTED
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HALTED: state_d = ST_HALTED;
      ST_FETCH: begin
        if (pc_is_zero) begin
          state_d = ST_HALTED;
        end else if (!waitrequest) begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (!div_busy) begin
          state_d = (is_load || is_store) ? ST_MEM : ST_WB;
        end
      end
      ST_MEM: begin
        if (!waitrequest) begin
          state_d = is_load ? ST_WB : ST_FETCH;
        end
      end
      ST_WB:   state_d = ST_FETCH;
      default: state_d = ST_HALTED;
    endcase
  end

  // Output decode; reset masks strobes combinationally so an open transfer drops at once
  always_comb begin
    active    = reset || (state_q != ST_HALTED);
    mem_read  = 1'b0;
    mem_write = 1'b0;
    addr_sel  = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    reg_write = 1'b0;
    if (!reset) begin
      case (state_q)
        ST_FETCH: begin
          if (!pc_is_zero) begin
            mem_read = 1'b1;
            ir_write = !waitrequest;
          end
        end
        ST_MEM: begin
          addr_sel  = 1'b1;
          mem_read  = is_load;
          mem_write = is_store && !is_load;
          pc_write  = !waitrequest && !is_load;
        end
        ST_WB: begin
          reg_write = 1'b1;
          pc_write  = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign state = state_q;

`ifdef MIPS_CPU_SEQ_CYCLE_COUNT_EN
  logic [CNT_W-1:0] cycle_count_q;
  logic [CNT_W-1:0] cycle_count_d;

  // Counter next value: advance while running, freeze once halted; wraps naturally
  always_comb begin
    cycle_count_d = cycle_count_q;
    if (active) begin
      cycle_count_d = cycle_count_q + CNT_W'(1);
    end
  end

  // Active-cycle counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_count_q <= '0;
    end else begin
      cycle_count_q <= cycle_count_d;
    end
  end

  assign cycle_count = cycle_count_q;
`else
  // Counter not built in this configuration
`endif

endmodule
